// File: rtl/traffic_pkg.sv
// Shared types for the intersection controllers: FSM state encoding and the
// per-state interval lookup used when a state is entered.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_REDYLW,
    S_FLASH
  } tl_state_e;

  // Value the down-counter loads on entry to a state (interval minus one).
  function automatic int time_to_load(input tl_state_e s, input int green_t,
                                      input int yellow_t, input int allred_t,
                                      input int redylw_t, input int flash_t);
    int t;
    case (s)
      S_GREEN:  t = green_t;
      S_YELLOW: t = yellow_t;
      S_ALLRED: t = allred_t;
      S_REDYLW: t = redylw_t;
      default:  t = flash_t;
    endcase
    return t - 1;
  endfunction

endpackage

// File: rtl/traffic_intersection_if.sv
// Detector/button inputs and lamp outputs of the intersection controller.
interface traffic_intersection_if #(
  parameter int N_PHASES = 2,
  parameter int PW       = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
);
  logic [N_PHASES-1:0] det;
  logic [N_PHASES-1:0] ped_req;
  logic                flash_req;
  logic [N_PHASES-1:0] red;
  logic [N_PHASES-1:0] yellow;
  logic [N_PHASES-1:0] green;
  logic [N_PHASES-1:0] walk;
  logic [PW-1:0]       cur_phase;
  logic                flashing;

  modport master (
    output det, ped_req, flash_req,
    input  red, yellow, green, walk, cur_phase, flashing
  );

  modport slave (
    input  det, ped_req, flash_req,
    output red, yellow, green, walk, cur_phase, flashing
  );
endinterface

// File: rtl/tl_phase_timer.sv
// Loadable down-counter that stops at zero; zero flag gates state exits.
module tl_phase_timer #(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (!rst)            cnt <= RST_VAL;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_intersection.sv
// Demand-actuated N-phase intersection controller with all-red clearance,
// red+yellow prepare, rest-in-green and flashing-yellow night mode.
module traffic_intersection
  import traffic_pkg::*;
#(
  parameter int N_PHASES = 2,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2,
  parameter int REDYLW_T = 4,
  parameter int FLASH_T  = 8
) (
  input logic clk,
  input logic rst,
  traffic_intersection_if.slave tif
);

  localparam int PW   = (N_PHASES > 2) ? $clog2(N_PHASES) : 1;
  localparam int M1   = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int M2   = (M1 > ALLRED_T) ? M1 : ALLRED_T;
  localparam int M3   = (M2 > REDYLW_T) ? M2 : REDYLW_T;
  localparam int MAXT = (M3 > FLASH_T) ? M3 : FLASH_T;
  localparam int TW   = $clog2(MAXT + 1);

  if (N_PHASES < 2 || N_PHASES > 8 || GREEN_T < 1 || YELLOW_T < 1 ||
      ALLRED_T < 1 || REDYLW_T < 1 || FLASH_T < 1) begin : g_bad_param
    $error("traffic_intersection: illegal parameter value");
  end

  tl_state_e           state, state_d;
  logic [PW-1:0]       cur, cur_d, nxt, nxt_d, rr;
  logic [N_PHASES-1:0] call, call_d, pend, pend_d, srv, srv_d;
  logic                blink, blink_d, found;
  logic                ld, tz;
  logic [TW-1:0]       tmr, ld_val;

  assign ld_val = TW'(time_to_load(state_d, GREEN_T, YELLOW_T, ALLRED_T,
                                   REDYLW_T, FLASH_T));

  tl_phase_timer #(.TW(TW), .RST_VAL(TW'(ALLRED_T - 1))) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .cnt      (tmr),
    .zero     (tz)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_ALLRED;
      cur   <= '0;
      nxt   <= '0;
      call  <= '0;
      pend  <= '0;
      srv   <= '0;
      blink <= 1'b0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
      nxt   <= nxt_d;
      call  <= call_d;
      pend  <= pend_d;
      srv   <= srv_d;
      blink <= blink_d;
    end
  end

  // Round-robin search from cur+1; scanning downward lets the nearest call win.
  always_comb begin
    rr    = PW'((int'(cur) + 1) % N_PHASES);
    found = 1'b0;
    for (int k = N_PHASES - 1; k >= 1; k--) begin
      if (call[(int'(cur) + k) % N_PHASES]) begin
        rr    = PW'((int'(cur) + k) % N_PHASES);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    cur_d   = cur;
    nxt_d   = nxt;
    call_d  = call | tif.det | tif.ped_req;
    pend_d  = pend | tif.ped_req;
    srv_d   = srv;
    blink_d = blink;
    ld      = 1'b0;
    case (state)
      S_ALLRED: if (tz) begin
        ld = 1'b1;
        if (tif.flash_req) begin
          state_d = S_FLASH;
          blink_d = 1'b1;
        end else begin
          state_d = S_REDYLW;
        end
      end
      S_REDYLW: if (tz) begin
        state_d      = S_GREEN;
        ld           = 1'b1;
        cur_d        = nxt;
        call_d[nxt]  = 1'b0;
        pend_d[nxt]  = 1'b0;
        srv_d[nxt]   = pend[nxt];
      end
      S_GREEN: if (tz && (found || tif.flash_req)) begin
        state_d = S_YELLOW;
        ld      = 1'b1;
        nxt_d   = rr;
      end
      S_YELLOW: if (tz) begin
        state_d = S_ALLRED;
        ld      = 1'b1;
      end
      S_FLASH: begin
        if (!tif.flash_req) begin
          state_d = S_ALLRED;
          ld      = 1'b1;
          nxt_d   = '0;
          call_d  = '0;
        end else if (tz) begin
          blink_d = ~blink;
          ld      = 1'b1;
        end
      end
      default: begin
        state_d = S_ALLRED;
        ld      = 1'b1;
      end
    endcase
  end

  always_comb begin
    tif.red    = '0;
    tif.yellow = '0;
    tif.green  = '0;
    tif.walk   = '0;
    for (int p = 0; p < N_PHASES; p++) begin
      case (state)
        S_GREEN: begin
          tif.green[p] = (PW'(p) == cur);
          tif.red[p]   = (PW'(p) != cur);
          tif.walk[p]  = (PW'(p) == cur) && srv[p];
        end
        S_YELLOW: begin
          tif.yellow[p] = (PW'(p) == cur);
          tif.red[p]    = (PW'(p) != cur);
        end
        S_REDYLW: begin
          tif.red[p]    = 1'b1;
          tif.yellow[p] = (PW'(p) == nxt);
        end
        S_FLASH:  tif.yellow[p] = blink;
        default:  tif.red[p]    = 1'b1;
      endcase
    end
  end

  assign tif.cur_phase = cur;
  assign tif.flashing  = (state == S_FLASH);

endmodule

// File: doc/traffic_intersection.md
Name: traffic_intersection

Overview:
- N-phase intersection controller, the successor to the single-signal fixed-cycle controller.
- Drives one red/yellow/green head and one pedestrian walk lamp per phase, at one phase at a time.
- Demand-actuated: phases without a call are skipped, and the active green rests when nobody else is waiting.
- Adds an all-red clearance interval and a flashing-yellow night mode.
- Sits under the top-level sign/lamp driver; all inputs arrive already synchronised to clk.

Parameters:
- N_PHASES, 2: number of phases (2..8).
- GREEN_T, 20: minimum green, cycles.
- YELLOW_T, 4: yellow, cycles.
- ALLRED_T, 2: all-red clearance, cycles.
- REDYLW_T, 4: red+yellow prepare interval before green, cycles.
- FLASH_T, 8: half-period of flash-mode blink, cycles.
- All times must be ≥1; elaboration-time assertion otherwise.
- Derived: PW=$clog2(N_PHASES) (min 1); TW=$clog2(max time + 1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-low (asserted when 0).
- det  in  N_PHASES  vehicle detector, one per phase, level.
- ped_req  in  N_PHASES  pedestrian button, one per phase, level.
- flash_req  in  1  night mode request, level.
- red, yellow, green  out  N_PHASES each  lamp drives per phase.
- walk  out  N_PHASES  pedestrian walk per phase.
- cur_phase  out  PW  phase currently served.
- flashing  out  1  high while in flash mode.

Behaviour:
- States: S_GREEN, S_YELLOW, S_ALLRED, S_REDYLW, S_FLASH.
- Registers: state, timer[TW], cur[PW], nxt[PW], call[N], ped_pend[N], ped_srv[N], blink.
- Timer:
  - On state entry, timer loads T-1 for that state.
  - Timer decrements each cycle while >0.
  - The state's exit condition is evaluated when timer==0.
- Reset (rst==0 at a clk edge):
  - state=S_ALLRED, timer=ALLRED_T-1, cur=0, nxt=0, all calls/pend/srv/blink=0.
  - Outputs: red all 1; yellow, green, walk all 0; cur_phase=0; flashing=0.
  - Reset mid-operation behaves identically; no output glitch beyond the next edge.
- Calls:
  - call[i] sets on det[i] or ped_req[i]; ped_pend[i] sets on ped_req[i].
  - Both clear for phase p on entry to S_GREEN(p). On that entry edge, clear wins over a simultaneous set for p only.
  - ped_srv[p] := ped_pend[p] at green entry.
  - A ped_req for the phase already in green sets ped_pend/call for the next service; walk never starts mid-green.
- Transitions:
  - S_ALLRED, timer==0:
    - flash_req → S_FLASH.
    - else → S_REDYLW, nxt already chosen.
  - S_REDYLW, timer==0 → S_GREEN, cur:=nxt.
  - S_GREEN, timer==0:
    - If any call[j], j≠cur, or flash_req → S_YELLOW.
      - nxt := first j with call[j] in round-robin order cur+1, cur+2, … mod N_PHASES.
      - If no such call (flash only), nxt := cur+1 mod N.
    - else hold S_GREEN with timer at 0 (rest in green).
  - S_YELLOW, timer==0 → S_ALLRED.
  - S_FLASH:
    - blink toggles every FLASH_T cycles, starting at 1 on entry.
    - On flash_req==0 → S_ALLRED with timer=ALLRED_T-1, nxt:=0, call cleared.
- Lamp decode for phase p (pure function of registers):
  - S_GREEN, p==cur: green=1.
  - S_YELLOW, p==cur: yellow=1.
  - S_REDYLW, p==nxt: red=1, yellow=1.
  - S_FLASH: yellow=blink, red=0, green=0, for all p.
  - Otherwise: red=1.
- walk[p] = ped_srv[p] while S_GREEN and p==cur; cleared on leaving green.
- Invariants:
  - At most one phase has green or yellow (except during flash).
  - Never green on two phases.
  - Every green is preceded by S_ALLRED then S_REDYLW.
  - flashing = (state==S_FLASH).
  - cur_phase = cur.

Decomposition:
- Shared package traffic_pkg: state enum tl_state_e and a time_to_load function.
  - Existing single-signal controller migrates to tl_state_e later.
- One sub-module: tl_phase_timer.
  - Loadable down-counter with a zero flag, parametrised by TW.
- State registers use the team DFF macros with active-low synchronous reset.

Test Plan:
- Reset release, N=2, defaults, no inputs:
  - cycles 0-1 all red.
  - cycles 2-5 red+yellow on phase 0.
  - green[0] from cycle 6 and held indefinitely (rest in green).
- Green[0] active, det[1] pulsed at cycle 10 after green entry:
  - green[0] for exactly 20 cycles, yellow[0] 4, all-red 2, red+yellow[1] 4, then green[1].
  - call[1] cleared at green[1] entry.
- N=4, calls on phases 3 and 1 while phase 0 is green:
  - service order 1 then 3; phase 2 is skipped.
- ped_req[1] during red:
  - walk[1]=1 for the whole green[1] and drops with yellow.
  - ped_req[1] during green[1] produces no walk until the next green[1].
- flash_req during green[0]:
  - yellow[0] 4, all-red 2, then yellow on all phases toggling every 8 cycles, red=green=0.
  - Drop flash_req → all-red 2, red+yellow[0], green[0].
- rst low for one cycle mid-yellow:
  - next cycle all red, timer restarts at ALLRED_T-1, calls cleared.
  - No two greens in any cycle throughout (checked by assertion).
